// File: rtl/link_allocator_pkt_if.sv
// Link allocator bus: per-channel request/tail/credit inputs and grant/credit status outputs.
// The allocator uses the slave modport; the requester side uses master.
interface link_allocator_pkt_if #(
    parameter int unsigned N_REQUEST_SIGNAL = 6,
    parameter int unsigned N_BITS_POINTER   = 3,
    parameter int unsigned N_BITS_CREDIT    = 3
);
    logic [N_REQUEST_SIGNAL-1:0] r_la_i;
    logic [N_REQUEST_SIGNAL-1:0] tail_i;
    logic                        credit_i;
    logic                        g_la_o;
    logic [N_BITS_POINTER-1:0]   g_channel_id_o;
    logic                        locked_o;
    logic [N_BITS_CREDIT-1:0]    credit_count_o;
    logic                        credit_err_o;

    modport master (
        output r_la_i, tail_i, credit_i,
        input  g_la_o, g_channel_id_o, locked_o, credit_count_o, credit_err_o
    );

    modport slave (
        input  r_la_i, tail_i, credit_i,
        output g_la_o, g_channel_id_o, locked_o, credit_count_o, credit_err_o
    );
endinterface

// File: rtl/link_allocator_pkt.sv
// Round-robin link allocator with optional packet locking and credit-based flow control.
// Grant is combinational from requests and registered state; credits gate every grant.
module link_allocator_pkt #(
    parameter int unsigned N_REQUEST_SIGNAL = 6,
    parameter int unsigned N_BITS_POINTER   = 3,
    parameter int unsigned N_CREDITS        = 4,
    parameter int unsigned N_BITS_CREDIT    = 3,
    parameter int unsigned PACKET_LOCK      = 1
) (
    input  logic              clk,
    input  logic              rst,
    link_allocator_pkt_if.slave bus
);

    localparam int unsigned NP = N_BITS_POINTER;
    localparam int unsigned NC = N_BITS_CREDIT;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [NP-1:0]   r_last_served, w_last_served_nxt;
    logic [NP-1:0]   r_owner, w_owner_nxt;
    logic [NC-1:0]   r_credit_count, w_credit_count_nxt;
    logic            r_credit_err, w_credit_err_nxt;

    logic            w_found_hi, w_found_lo, w_found;
    logic [NP-1:0]   w_win_hi, w_win_lo, w_winner;
    logic            w_credit_ok, w_grant, w_tail;
    logic [NP-1:0]   w_id;

    // Rotating priority: channels above last_served first, then wrap to 0..last_served.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = 0; i < int'(N_REQUEST_SIGNAL); i++) begin
            if (bus.r_la_i[i] && !w_found_hi && (NP'(i) > r_last_served)) begin
                w_found_hi = 1'b1;
                w_win_hi   = NP'(i);
            end
        end
        for (int i = 0; i < int'(N_REQUEST_SIGNAL); i++) begin
            if (bus.r_la_i[i] && !w_found_lo && (NP'(i) <= r_last_served)) begin
                w_found_lo = 1'b1;
                w_win_lo   = NP'(i);
            end
        end
        w_found  = w_found_hi | w_found_lo;
        w_winner = w_found_hi ? w_win_hi : (w_found_lo ? w_win_lo : r_last_served);
    end

    // Grant, lock FSM and credit next-state; reset also masks the grant.
    always_comb begin
        w_state_nxt        = r_state;
        w_last_served_nxt  = r_last_served;
        w_owner_nxt        = r_owner;
        w_credit_count_nxt = r_credit_count;
        w_credit_err_nxt   = r_credit_err;
        w_grant            = 1'b0;
        w_tail             = 1'b0;
        w_id               = r_last_served;
        w_credit_ok        = rst && (r_credit_count != '0);

        case (r_state)
            IDLE: begin
                if (w_credit_ok && w_found) begin
                    w_grant = 1'b1;
                    w_id    = w_winner;
                    w_tail  = bus.tail_i[w_winner];
                end
                if (w_grant && !w_tail && (PACKET_LOCK != 0)) begin
                    w_state_nxt = LOCKED;
                    w_owner_nxt = w_winner;
                end
            end
            LOCKED: begin
                w_id = r_owner;
                if (w_credit_ok && bus.r_la_i[r_owner]) begin
                    w_grant = 1'b1;
                    w_tail  = bus.tail_i[r_owner];
                end
                if (w_grant && w_tail) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_grant) begin
            w_last_served_nxt = w_id;
        end

        if (bus.credit_i && !w_grant) begin
            if (r_credit_count == NC'(N_CREDITS)) begin
                w_credit_err_nxt = 1'b1;
            end else begin
                w_credit_count_nxt = r_credit_count + NC'(1);
            end
        end else if (w_grant && !bus.credit_i) begin
            w_credit_count_nxt = r_credit_count - NC'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_last_served  <= '0;
            r_owner        <= '0;
            r_credit_count <= NC'(N_CREDITS);
            r_credit_err   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_last_served  <= w_last_served_nxt;
            r_owner        <= w_owner_nxt;
            r_credit_count <= w_credit_count_nxt;
            r_credit_err   <= w_credit_err_nxt;
        end
    end

    assign bus.g_la_o         = w_grant;
    assign bus.g_channel_id_o = w_id;
    assign bus.locked_o       = (r_state == LOCKED);
    assign bus.credit_count_o = r_credit_count;
    assign bus.credit_err_o   = r_credit_err;

endmodule

// File: tb/tb_link_allocator_pkt.sv
// Directed bench for link_allocator_pkt: vector table plus lock, bubble and async-reset sequences.
// Instance a has packet locking enabled, instance b re-arbitrates every flit.
module tb_link_allocator_pkt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] r_la;
    logic [5:0] tail;
    logic       credit;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    link_allocator_pkt_if #(.N_REQUEST_SIGNAL(6), .N_BITS_POINTER(3), .N_BITS_CREDIT(3)) if_a ();
    link_allocator_pkt_if #(.N_REQUEST_SIGNAL(6), .N_BITS_POINTER(3), .N_BITS_CREDIT(3)) if_b ();

    assign if_a.r_la_i   = r_la;
    assign if_a.tail_i   = tail;
    assign if_a.credit_i = credit;
    assign if_b.r_la_i   = r_la;
    assign if_b.tail_i   = tail;
    assign if_b.credit_i = credit;

    link_allocator_pkt #(
        .N_REQUEST_SIGNAL(6), .N_BITS_POINTER(3), .N_CREDITS(4), .N_BITS_CREDIT(3), .PACKET_LOCK(1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (if_a)
    );

    link_allocator_pkt #(
        .N_REQUEST_SIGNAL(6), .N_BITS_POINTER(3), .N_CREDITS(4), .N_BITS_CREDIT(3), .PACKET_LOCK(0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (if_b)
    );

    typedef struct {
        logic [5:0] r_la;
        logic [5:0] tail;
        logic       credit;
        logic       g;
        logic [2:0] id;
        logic       lock;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs are sampled 2 time units later.
    task automatic apply(input logic [5:0] rl, input logic [5:0] tl, input logic cr);
        @(negedge clk);
        r_la   = rl;
        tail   = tl;
        credit = cr;
        #2;
    endtask

    task automatic chk_a(input string nm, input logic g, input logic [2:0] id, input logic lk,
                         input logic [2:0] cnt, input logic err);
        chk({nm, " a.g_la"},   32'(if_a.g_la_o),         32'(g));
        chk({nm, " a.id"},     32'(if_a.g_channel_id_o), 32'(id));
        chk({nm, " a.locked"}, 32'(if_a.locked_o),       32'(lk));
        chk({nm, " a.count"},  32'(if_a.credit_count_o), 32'(cnt));
        chk({nm, " a.err"},    32'(if_a.credit_err_o),   32'(err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        r_la   = '0;
        tail   = '0;
        credit = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        r_la   = 6'b111111;
        tail   = 6'b111111;
        credit = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_a("reset", 1'b0, 3'd0, 1'b0, 3'd4, 1'b0);
        chk("reset b.g_la", 32'(if_b.g_la_o), 32'd0);
        @(negedge clk);
        r_la   = '0;
        tail   = '0;
        credit = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin ch1/ch2, credit exhaustion, ch4 credit pulse, saturation error, grant+credit.
        vecs[0]  = '{6'b000110, 6'b111111, 1'b0, 1'b1, 3'd1, 1'b0, 3'd4, 1'b0};
        vecs[1]  = '{6'b000110, 6'b111111, 1'b0, 1'b1, 3'd2, 1'b0, 3'd3, 1'b0};
        vecs[2]  = '{6'b000110, 6'b111111, 1'b0, 1'b1, 3'd1, 1'b0, 3'd2, 1'b0};
        vecs[3]  = '{6'b000110, 6'b111111, 1'b0, 1'b1, 3'd2, 1'b0, 3'd1, 1'b0};
        vecs[4]  = '{6'b000110, 6'b111111, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0};
        vecs[5]  = '{6'b010000, 6'b111111, 1'b1, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0};
        vecs[6]  = '{6'b010000, 6'b111111, 1'b0, 1'b1, 3'd4, 1'b0, 3'd1, 1'b0};
        vecs[7]  = '{6'b010000, 6'b111111, 1'b0, 1'b0, 3'd4, 1'b0, 3'd0, 1'b0};
        vecs[8]  = '{6'b000000, 6'b111111, 1'b1, 1'b0, 3'd4, 1'b0, 3'd0, 1'b0};
        vecs[9]  = '{6'b000000, 6'b111111, 1'b1, 1'b0, 3'd4, 1'b0, 3'd1, 1'b0};
        vecs[10] = '{6'b000000, 6'b111111, 1'b1, 1'b0, 3'd4, 1'b0, 3'd2, 1'b0};
        vecs[11] = '{6'b000000, 6'b111111, 1'b1, 1'b0, 3'd4, 1'b0, 3'd3, 1'b0};
        vecs[12] = '{6'b000000, 6'b111111, 1'b0, 1'b0, 3'd4, 1'b0, 3'd4, 1'b0};
        vecs[13] = '{6'b000000, 6'b111111, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4, 1'b0};
        vecs[14] = '{6'b000000, 6'b111111, 1'b0, 1'b0, 3'd4, 1'b0, 3'd4, 1'b1};
        vecs[15] = '{6'b000001, 6'b111111, 1'b1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1};
        vecs[16] = '{6'b000000, 6'b111111, 1'b0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1};

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].r_la, vecs[i].tail, vecs[i].credit);
            chk_a($sformatf("row%0d", i), vecs[i].g, vecs[i].id, vecs[i].lock, vecs[i].cnt, vecs[i].err);
            chk($sformatf("row%0d b.g_la", i), 32'(if_b.g_la_o),         32'(vecs[i].g));
            chk($sformatf("row%0d b.id", i),   32'(if_b.g_channel_id_o), 32'(vecs[i].id));
        end

        // Lock ch3, then drop reset mid-cycle: everything clears at once.
        apply(6'b001000, 6'b000000, 1'b0);
        chk_a("arst pre1", 1'b1, 3'd3, 1'b0, 3'd4, 1'b1);
        apply(6'b001000, 6'b000000, 1'b0);
        chk_a("arst pre2", 1'b1, 3'd3, 1'b1, 3'd3, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_a("arst", 1'b0, 3'd0, 1'b0, 3'd4, 1'b0);
        chk("arst b.err",   32'(if_b.credit_err_o),   32'd0);
        chk("arst b.count", 32'(if_b.credit_count_o), 32'd4);
        @(negedge clk);
        r_la = '0;
        tail = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // 3-flit packet on ch3 against continuous ch0, credit returned every cycle.
        apply(6'b001001, 6'b000000, 1'b1);
        chk_a("pkt c1", 1'b1, 3'd3, 1'b0, 3'd4, 1'b0);
        chk("pkt c1 b.id", 32'(if_b.g_channel_id_o), 32'd3);
        apply(6'b001001, 6'b000000, 1'b1);
        chk_a("pkt c2", 1'b1, 3'd3, 1'b1, 3'd4, 1'b0);
        chk("pkt c2 b.id", 32'(if_b.g_channel_id_o), 32'd0);
        chk("pkt c2 b.locked", 32'(if_b.locked_o), 32'd0);
        apply(6'b001001, 6'b001000, 1'b1);
        chk_a("pkt c3", 1'b1, 3'd3, 1'b1, 3'd4, 1'b0);
        chk("pkt c3 b.id", 32'(if_b.g_channel_id_o), 32'd3);
        chk("pkt c3 b.locked", 32'(if_b.locked_o), 32'd0);
        apply(6'b000001, 6'b000000, 1'b1);
        chk_a("pkt c4", 1'b1, 3'd0, 1'b0, 3'd4, 1'b0);
        chk("pkt c4 b.id", 32'(if_b.g_channel_id_o), 32'd0);
        chk("pkt c4 b.count", 32'(if_b.credit_count_o), 32'd4);
        chk("pkt c4 b.err", 32'(if_b.credit_err_o), 32'd0);

        // Bubble while locked on ch3: ch5 must wait.
        do_reset();
        apply(6'b001000, 6'b000000, 1'b0);
        chk_a("bub c1", 1'b1, 3'd3, 1'b0, 3'd4, 1'b0);
        apply(6'b100000, 6'b000000, 1'b0);
        chk_a("bub c2", 1'b0, 3'd3, 1'b1, 3'd3, 1'b0);
        apply(6'b100000, 6'b000000, 1'b0);
        chk_a("bub c3", 1'b0, 3'd3, 1'b1, 3'd3, 1'b0);
        apply(6'b101000, 6'b001000, 1'b0);
        chk_a("bub c4", 1'b1, 3'd3, 1'b1, 3'd3, 1'b0);
        apply(6'b100000, 6'b000000, 1'b0);
        chk_a("bub c5", 1'b1, 3'd5, 1'b0, 3'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
